// File: rtl/mem_test_pkg.sv
// rtl/mem_test_pkg.sv - shared types and codes for the memory pattern tester
//
// Purpose: state encoding of the tester FSM and the pattern selector codes,
// shared by mem_pattern_tester and mem_pattern_gen.
// Ports: none (package).
package mem_test_pkg;

  localparam logic [1:0] PAT_CODE_CONST    = 2'd0;
  localparam logic [1:0] PAT_CODE_ADDR     = 2'd1;
  localparam logic [1:0] PAT_CODE_INV_ADDR = 2'd2;
  localparam logic [1:0] PAT_CODE_WALK1    = 2'd3;

  typedef enum logic [1:0] {
    PAT_CONST    = PAT_CODE_CONST,
    PAT_ADDR     = PAT_CODE_ADDR,
    PAT_INV_ADDR = PAT_CODE_INV_ADDR,
    PAT_WALK1    = PAT_CODE_WALK1
  } pattern_t;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR_REQ  = 3'd1,
    S_WR_WAIT = 3'd2,
    S_RD_REQ  = 3'd3,
    S_RD_WAIT = 3'd4,
    S_FINISH  = 3'd5
  } state_t;

endpackage

// File: rtl/mem_pattern_gen.sv
// rtl/mem_pattern_gen.sv - combinational expected-word generator
//
// Purpose: maps (pattern, seed, addr) to the word written at addr and later
// expected back on the read of addr.
// Ports:
//   pattern  in   2       pattern selector code
//   seed     in   DATA_W  pattern seed
//   addr     in   ADDR_W  word address
//   word     out  DATA_W  expected word
module mem_pattern_gen
  import mem_test_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 16
) (
  input  logic [1:0]        pattern,
  input  logic [DATA_W-1:0] seed,
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] word
);

  localparam int SH_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  logic [DATA_W-1:0] addr_lo;
  logic [SH_W-1:0]   rot;
  logic [SH_W:0]     rot_back;
  logic [DATA_W-1:0] walk;
  logic              unused_addr_hi;

  assign addr_lo = addr[DATA_W-1:0];

  // DATA_W is a power of two, so a mod DATA_W is just the low address bits.
  assign rot      = addr[SH_W-1:0];
  assign rot_back = (SH_W+1)'(DATA_W) - {1'b0, rot};

  // A right shift by the full width yields zero, so rot=0 returns seed.
  assign walk = (seed << rot) | (seed >> rot_back);

  assign unused_addr_hi = ^addr[ADDR_W-1:DATA_W];

  always_comb begin
    word = seed;
    case (pattern_t'(pattern))
      PAT_CONST:    word = seed;
      PAT_ADDR:     word = addr_lo ^ seed;
      PAT_INV_ADDR: word = ~(addr_lo ^ seed);
      PAT_WALK1:    word = walk;
      default:      word = seed;
    endcase
  end

endmodule

// File: rtl/mem_pattern_tester.sv
// rtl/mem_pattern_tester.sv - write-then-readback memory pattern tester
//
// Purpose: writes a pattern over [base_addr, end_addr] through a
// request/grant/commit write port, reads it back through a
// request/grant/valid read port, counts mismatches and records the first.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   start, abort                    one-cycle control pulses
//   pattern, seed                   pattern selection and seed
//   base_addr, end_addr             inclusive address range
//   busy, done, pass                status (done/pass held until next start)
//   err_count                       saturating mismatch count
//   first_err_addr, first_err_data  first mismatch capture
//   writeRequest/Grant/Address/Data/Commit  write controller port
//   readRequest/Grant/Address/Data/Valid    read controller port
module mem_pattern_tester
  import mem_test_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 16,
  parameter int ERR_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [1:0]        pattern,
  input  logic [DATA_W-1:0] seed,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] end_addr,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [DATA_W-1:0] first_err_data,
  output logic              writeRequest,
  input  logic              writeRequestGrant,
  output logic [ADDR_W-1:0] writeAddress,
  output logic [DATA_W-1:0] writeData,
  input  logic              writeCommit,
  output logic              readRequest,
  input  logic              readRequestGrant,
  output logic [ADDR_W-1:0] readAddress,
  input  logic [DATA_W-1:0] readData,
  input  logic              readValid
);

  state_t            state;
  logic [1:0]        pat_q;
  logic [DATA_W-1:0] seed_q;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] end_q;
  logic [ADDR_W-1:0] cur;
  // Set by an abort, or by an empty range; either way the run cannot pass.
  logic              abort_q;
  logic              first_seen;
  logic [DATA_W-1:0] exp_word;

  // One generator on the current address serves both the write data and
  // the read compare, so the two can never disagree.
  mem_pattern_gen #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_gen (
    .pattern (pat_q),
    .seed    (seed_q),
    .addr    (cur),
    .word    (exp_word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      pat_q          <= '0;
      seed_q         <= '0;
      base_q         <= '0;
      end_q          <= '0;
      cur            <= '0;
      abort_q        <= 1'b0;
      first_seen     <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
      first_err_data <= '0;
      writeRequest   <= 1'b0;
      writeAddress   <= '0;
      writeData      <= '0;
      readRequest    <= 1'b0;
      readAddress    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            pat_q          <= pattern;
            seed_q         <= seed;
            base_q         <= base_addr;
            end_q          <= end_addr;
            cur            <= base_addr;
            busy           <= 1'b1;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_count      <= '0;
            first_err_addr <= '0;
            first_err_data <= '0;
            first_seen     <= 1'b0;
            abort_q        <= 1'b0;
            if (end_addr < base_addr) begin
              abort_q <= 1'b1;
              state   <= S_FINISH;
            end else begin
              state <= S_WR_REQ;
            end
          end
        end

        // The first WR_REQ cycle loads address/data from the freshly
        // updated cur; the request is then held stable until granted.
        S_WR_REQ: begin
          if (!writeRequest) begin
            if (abort) begin
              abort_q <= 1'b1;
              state   <= S_FINISH;
            end else begin
              writeRequest <= 1'b1;
              writeAddress <= cur;
              writeData    <= exp_word;
            end
          end else if (writeRequestGrant) begin
            // A grant beats a coincident abort; the abort waits for commit.
            writeRequest <= 1'b0;
            if (abort) abort_q <= 1'b1;
            state <= S_WR_WAIT;
          end else if (abort) begin
            writeRequest <= 1'b0;
            abort_q      <= 1'b1;
            state        <= S_FINISH;
          end
        end

        S_WR_WAIT: begin
          if (abort) abort_q <= 1'b1;
          if (writeCommit) begin
            if (abort_q || abort) begin
              state <= S_FINISH;
            end else if (cur == end_q) begin
              cur   <= base_q;
              state <= S_RD_REQ;
            end else begin
              cur   <= cur + ADDR_W'(1);
              state <= S_WR_REQ;
            end
          end
        end

        S_RD_REQ: begin
          if (!readRequest) begin
            if (abort) begin
              abort_q <= 1'b1;
              state   <= S_FINISH;
            end else begin
              readRequest <= 1'b1;
              readAddress <= cur;
            end
          end else if (readRequestGrant) begin
            readRequest <= 1'b0;
            if (abort) abort_q <= 1'b1;
            state <= S_RD_WAIT;
          end else if (abort) begin
            readRequest <= 1'b0;
            abort_q     <= 1'b1;
            state       <= S_FINISH;
          end
        end

        S_RD_WAIT: begin
          if (abort) abort_q <= 1'b1;
          if (readValid) begin
            if (readData != exp_word) begin
              if (err_count != {ERR_W{1'b1}}) err_count <= err_count + ERR_W'(1);
              if (!first_seen) begin
                first_seen     <= 1'b1;
                first_err_addr <= cur;
                first_err_data <= readData;
              end
            end
            // Compare against end before incrementing so end=all-ones
            // terminates instead of wrapping to zero.
            if (abort_q || abort || (cur == end_q)) begin
              state <= S_FINISH;
            end else begin
              cur   <= cur + ADDR_W'(1);
              state <= S_RD_REQ;
            end
          end
        end

        S_FINISH: begin
          busy    <= 1'b0;
          done    <= 1'b1;
          pass    <= (err_count == '0) && !abort_q;
          abort_q <= 1'b0;
          state   <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_pattern_tester.sv
// tb/tb_mem_pattern_tester.sv - directed bench for mem_pattern_tester
//
// Purpose: drives directed runs against a controller model with random
// 0-5 cycle grant/commit/valid delays and an ideal memory.
// Ports: none (top-level bench).
module tb_mem_pattern_tester;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 16;
  localparam int ERR_W  = 16;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic              abort;
  logic [1:0]        pattern;
  logic [DATA_W-1:0] seed;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W-1:0] end_addr;
  logic              busy;
  logic              done;
  logic              pass;
  logic [ERR_W-1:0]  err_count;
  logic [ADDR_W-1:0] first_err_addr;
  logic [DATA_W-1:0] first_err_data;
  logic              writeRequest;
  logic              writeRequestGrant;
  logic [ADDR_W-1:0] writeAddress;
  logic [DATA_W-1:0] writeData;
  logic              writeCommit;
  logic              readRequest;
  logic              readRequestGrant;
  logic [ADDR_W-1:0] readAddress;
  logic [DATA_W-1:0] readData;
  logic              readValid;

  mem_pattern_tester #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .ERR_W  (ERR_W)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .start             (start),
    .abort             (abort),
    .pattern           (pattern),
    .seed              (seed),
    .base_addr         (base_addr),
    .end_addr          (end_addr),
    .busy              (busy),
    .done              (done),
    .pass              (pass),
    .err_count         (err_count),
    .first_err_addr    (first_err_addr),
    .first_err_data    (first_err_data),
    .writeRequest      (writeRequest),
    .writeRequestGrant (writeRequestGrant),
    .writeAddress      (writeAddress),
    .writeData         (writeData),
    .writeCommit       (writeCommit),
    .readRequest       (readRequest),
    .readRequestGrant  (readRequestGrant),
    .readAddress       (readAddress),
    .readData          (readData),
    .readValid         (readValid)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [DATA_W-1:0] mem [logic [ADDR_W-1:0]];
  logic [ADDR_W-1:0] wr_addr_q[$];
  logic [DATA_W-1:0] wr_data_q[$];
  int                wr_cnt;
  int                rd_cnt;
  logic              hold_en;
  logic [ADDR_W-1:0] hold_addr;
  logic              flip_en;
  logic [ADDR_W-1:0] flip_addr;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Write side of the controller model.
  initial begin
    writeRequestGrant = 1'b0;
    writeCommit       = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && writeRequest && !(hold_en && writeAddress == hold_addr)) begin
        repeat ($urandom_range(0, 5)) @(negedge clk);
        if (rst_n && writeRequest) begin
          mem[writeAddress] = writeData;
          wr_addr_q.push_back(writeAddress);
          wr_data_q.push_back(writeData);
          wr_cnt++;
          writeRequestGrant = 1'b1;
          @(negedge clk);
          writeRequestGrant = 1'b0;
          repeat ($urandom_range(0, 5)) @(negedge clk);
          writeCommit = 1'b1;
          @(negedge clk);
          writeCommit = 1'b0;
        end
      end
    end
  end

  // Read side of the controller model.
  initial begin
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rv;
    readRequestGrant = 1'b0;
    readValid        = 1'b0;
    readData         = '0;
    forever begin
      @(negedge clk);
      if (rst_n && readRequest) begin
        repeat ($urandom_range(0, 5)) @(negedge clk);
        if (rst_n && readRequest) begin
          ra = readAddress;
          rd_cnt++;
          readRequestGrant = 1'b1;
          @(negedge clk);
          readRequestGrant = 1'b0;
          repeat ($urandom_range(0, 5)) @(negedge clk);
          rv = mem.exists(ra) ? mem[ra] : '0;
          if (flip_en && ra == flip_addr) rv[0] = ~rv[0];
          readData  = rv;
          readValid = 1'b1;
          @(negedge clk);
          readValid = 1'b0;
          readData  = '0;
        end
      end
    end
  end

  task automatic clear_logs();
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_cnt = 0;
    rd_cnt = 0;
  endtask

  task automatic pulse_start(input logic [1:0] p, input logic [DATA_W-1:0] s,
                             input logic [ADDR_W-1:0] b, input logic [ADDR_W-1:0] e);
    clear_logs();
    @(negedge clk);
    pattern   = p;
    seed      = s;
    base_addr = b;
    end_addr  = e;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 3000 && !done; i++) @(negedge clk);
    check(tag, done, 1'b1);
  endtask

  task automatic check_outputs_zero(input string tag);
    logic [63:0] acc;
    acc = {63'd0, busy} | {63'd0, done} | {63'd0, pass} |
          {63'd0, writeRequest} | {63'd0, readRequest} |
          {32'd0, writeAddress} | {32'd0, readAddress} | {48'd0, writeData} |
          {48'd0, err_count} | {32'd0, first_err_addr} | {48'd0, first_err_data};
    check(tag, acc, 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    pattern = 2'd0;
    seed = '0;
    base_addr = '0;
    end_addr = '0;
    hold_en = 1'b0;
    hold_addr = '0;
    flip_en = 1'b0;
    flip_addr = '0;
    clear_logs();
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset_outputs");
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_busy", busy, 1'b0);

    // V1: ADDR pattern, seed 0, 0..15
    pulse_start(2'd1, 16'h0000, 32'd0, 32'd15);
    check("v1_busy", busy, 1'b1);
    wait_done("v1_done");
    check("v1_pass", pass, 1'b1);
    check("v1_err", err_count, 16'd0);
    check("v1_wr_cnt", wr_cnt, 16);
    check("v1_rd_cnt", rd_cnt, 16);
    check("v1_busy_end", busy, 1'b0);
    if (wr_data_q.size() > 5) check("v1_wdata5", wr_data_q[5], 16'h0005);
    else check("v1_wdata5_missing", wr_data_q.size(), 16);

    // V2: CONST A5A5, bit0 flipped on the read of address 7
    flip_en = 1'b1;
    flip_addr = 32'd7;
    pulse_start(2'd0, 16'hA5A5, 32'd0, 32'd15);
    wait_done("v2_done");
    check("v2_pass", pass, 1'b0);
    check("v2_err", err_count, 16'd1);
    check("v2_first_addr", first_err_addr, 32'd7);
    check("v2_first_data", first_err_data, 16'hA5A4);
    check("v2_rd_cnt", rd_cnt, 16);
    flip_en = 1'b0;

    // V3: WALK1 seed 1 over 14..17
    pulse_start(2'd3, 16'h0001, 32'd14, 32'd17);
    wait_done("v3_done");
    check("v3_pass", pass, 1'b1);
    check("v3_wr_cnt", wr_cnt, 4);
    if (wr_data_q.size() == 4) begin
      check("v3_wdata0", wr_data_q[0], 16'h4000);
      check("v3_wdata1", wr_data_q[1], 16'h8000);
      check("v3_wdata2", wr_data_q[2], 16'h0001);
      check("v3_wdata3", wr_data_q[3], 16'h0002);
      check("v3_waddr3", wr_addr_q[3], 32'd17);
    end

    // V4: abort while the write at address 3 is waiting for grant
    hold_en = 1'b1;
    hold_addr = 32'd3;
    pulse_start(2'd1, 16'h0000, 32'd0, 32'd15);
    begin
      int n;
      n = 0;
      while (!(writeRequest && writeAddress == 32'd3) && n < 3000) begin
        @(negedge clk);
        n++;
      end
      check("v4_reached_addr3", writeRequest && writeAddress == 32'd3, 1'b1);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("v4_req_drop", writeRequest, 1'b0);
    wait_done("v4_done");
    check("v4_pass", pass, 1'b0);
    repeat (3) @(negedge clk);
    check("v4_no_more_req", {writeRequest, readRequest}, 2'b00);
    check("v4_wr_cnt", wr_cnt, 3);
    check("v4_rd_cnt", rd_cnt, 0);
    hold_en = 1'b0;

    // V5: empty range
    pulse_start(2'd1, 16'h0000, 32'd5, 32'd4);
    check("v5_req_c1", {writeRequest, readRequest}, 2'b00);
    @(negedge clk);
    check("v5_req_c2", {writeRequest, readRequest}, 2'b00);
    check("v5_done", done, 1'b1);
    check("v5_pass", pass, 1'b0);
    check("v5_wr_cnt", wr_cnt, 0);

    // V6: single all-ones address, then reset during the read
    pulse_start(2'd1, 16'h1234, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done("v6_done");
    check("v6_pass", pass, 1'b1);
    check("v6_wr_cnt", wr_cnt, 1);
    check("v6_rd_cnt", rd_cnt, 1);
    repeat (4) @(negedge clk);
    check("v6_no_wrap", {busy, writeRequest, readRequest}, 3'b000);
    if (wr_addr_q.size() == 1) check("v6_waddr", wr_addr_q[0], 32'hFFFF_FFFF);

    pulse_start(2'd1, 16'h1234, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    begin
      int n;
      n = 0;
      while (!readRequest && n < 3000) begin
        @(negedge clk);
        n++;
      end
      check("v6_reached_read", readRequest, 1'b1);
    end
    rst_n = 1'b0;
    #1;
    check_outputs_zero("v6_reset_mid_read");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check_outputs_zero("v6_after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_pattern_tester.md
MEM_PATTERN_TESTER -- requirements
Module: mem_pattern_tester

Interface
REQ-001 Parameter ADDR_W, 32, width of memory word address.
REQ-002 Parameter DATA_W, 16, width of memory data word; SHALL be a power of two.
REQ-003 Parameter ERR_W, 16, width of error counter.
REQ-004 Ports, in order:
- clk  in  1  memory clock; all logic on its rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle pulse; launches a test when idle
- abort  in  1  one-cycle pulse; ends the running test
- pattern  in  2  0=CONST, 1=ADDR, 2=INV_ADDR, 3=WALK1
- seed  in  DATA_W  pattern seed
- base_addr  in  ADDR_W  first address, inclusive
- end_addr  in  ADDR_W  last address, inclusive
- busy  out  1  test in progress
- done  out  1  level; test finished, held until next start
- pass  out  1  valid while done; 1 = zero errors and not aborted
- err_count  out  ERR_W  mismatches seen
- first_err_addr  out  ADDR_W  address of first mismatch
- first_err_data  out  DATA_W  data read at first mismatch
- writeRequest  out  1; writeRequestGrant  in  1; writeAddress  out  ADDR_W; writeData  out  DATA_W; writeCommit  in  1
- readRequest  out  1; readRequestGrant  in  1; readAddress  out  ADDR_W; readData  in  DATA_W; readValid  in  1

Function
REQ-005 Expected word for address a: CONST = seed; ADDR = a[DATA_W-1:0] ^ seed; INV_ADDR = ~(a[DATA_W-1:0] ^ seed); WALK1 = seed rotated left by (a mod DATA_W).
REQ-006 States: IDLE, WR_REQ, WR_WAIT, RD_REQ, RD_WAIT, FINISH.
REQ-007 IDLE + start: latch pattern, seed, base_addr and end_addr; clear err_count, first_err_*, done and pass; busy=1 on the next cycle. If end_addr < base_addr, go to FINISH with pass=0. Otherwise set cur=base and go to WR_REQ.
REQ-008 start while busy SHALL be ignored.
REQ-009 WR_REQ: writeRequest=1, writeAddress=cur, writeData=expected(cur), all stable until grant. On writeRequestGrant=1 go to WR_WAIT; writeRequest=0 from the next cycle.
REQ-010 WR_WAIT: on writeCommit=1, if cur==end_addr then cur=base and go to RD_REQ, else cur+1 and go to WR_REQ. Commit is sampled only in WR_WAIT.
REQ-011 RD_REQ/RD_WAIT: same handshake as writes using readRequest/readRequestGrant/readAddress. In RD_WAIT, readValid=1 compares readData with expected(cur).
REQ-012 On a mismatch, err_count increments and saturates at all-ones. On the first mismatch only, capture first_err_addr=cur and first_err_data=readData.
REQ-013 After the read at cur==end_addr, go to FINISH. The address compare happens before the increment, so end_addr=all-ones never wraps.
REQ-014 FINISH (one cycle): busy=0, done=1, pass=(err_count==0 && !aborted), then go to IDLE.
REQ-015 Abort in IDLE is ignored. Abort in WR_REQ/RD_REQ before grant drops the request next cycle and goes to FINISH. Abort in WR_WAIT/RD_WAIT is latched and taken after commit/valid. Abort forces pass=0.
REQ-016 Abort coincident with grant: the grant wins, and the abort is latched as in WR_WAIT/RD_WAIT.
REQ-017 Single-address range (base==end): exactly one write and one read.

Reset
REQ-018 rst_n low: state=IDLE; all outputs 0 (busy, done, pass, requests, addresses, data, err_count, first_err_*); latched abort cleared.
REQ-019 Reset asserted mid-transaction drops requests immediately with no completion wait; the controller is reset in the same domain.

Structure
REQ-020 Package mem_test_pkg holds the state enum, the pattern enum, and the pattern code constants.
REQ-021 Sub-module mem_pattern_gen: combinational, parametrised by ADDR_W/DATA_W, maps (pattern, seed, addr) to the expected word. It is used for both writeData and the compare.

Verification
REQ-022 Bench uses a controller model with random 0-5 cycle grant/commit/valid delays and an ideal memory:
- V1: ADDR pattern, seed=0, base=0, end=15 -> 16 writes, 16 reads, done=1, pass=1, err_count=0.
- V2: model flips bit0 of the read at address 7, CONST seed=16'hA5A5 -> pass=0, err_count=1, first_err_addr=7, first_err_data=16'hA5A4.
- V3: WALK1, seed=1, base=14, end=17 -> writes 16'h4000, 16'h8000, 16'h0001, 16'h0002.
- V4: abort while waiting for the write grant at address 3 -> request drops next cycle, no further requests, done=1, pass=0.
- V5: base=5, end=4 -> done=1, pass=0, and no requests within 2 cycles of start.
- V6: base=end=all-ones -> one write and one read, then done; rst_n pulsed mid-read leaves all outputs 0.
